// File: rtl/pdm_capture_mc_if.sv
// Register-side bus of pdm_capture_mc: command, read address, read data and status.
interface pdm_capture_mc_if #(
  parameter int ADDR_W = 10
);
  logic [1:0]      ctrl;
  logic [31:0]     addr;
  logic [31:0]     dout;
  logic            bsy;
  logic            done;
  logic [ADDR_W:0] word_cnt;

  modport master (output ctrl, addr, input dout, bsy, done, word_cnt);
  modport slave  (input ctrl, addr, output dout, bsy, done, word_cnt);
endinterface

// File: rtl/pdm_capture_mc.sv
// Multi-channel PDM capture: generates pdm_clk, samples one or two channels on opposite
// clock phases and packs bits MSB-first into 32-bit words of a word-addressed buffer.
module pdm_capture_mc #(
  parameter int CLK_DIV  = 33,
  parameter int CHANNELS = 1,
  parameter int ADDR_W   = 10
) (
  input  logic            AHBclk,
  input  logic            rst,
  input  logic            pdm_in,
  output logic            pdm_clk,
  pdm_capture_mc_if.slave bus
);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [7:0]      CNT_MAX   = 8'(CLK_DIV - 1);
  localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W + 1)'(DEPTH - CHANNELS);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_next;

  logic [1:0]        sync;
  logic [7:0]        cnt;
  logic [31:0]       sr0, sr1;
  logic [4:0]        bc0;
  logic              pend;
  logic [ADDR_W:0]   word_cnt;
  logic [31:0]       dout;
  logic [31:0]       mem [DEPTH];

  logic              sample, ready, capturing, tick;
  logic              cmd_start, cmd_clear, cmd_abort;
  logic              wr0, wr1, last_write;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_addr_bits;

  assign sample     = sync[1];
  assign ready      = (state == IDLE) || (state == DONE);
  assign cmd_start  = ready && (bus.ctrl == 2'b01);
  assign cmd_clear  = ready && (bus.ctrl == 2'b10);
  assign cmd_abort  = (state == CAPTURE) && (bus.ctrl == 2'b11);
  assign capturing  = (state == CAPTURE) && !cmd_abort;
  assign tick       = capturing && (cnt == CNT_MAX);
  assign wr0        = tick && pdm_clk && (bc0 == 5'd31);
  assign wr1        = capturing && pend;
  // The final write of a capture is the ch0 word (mono) or the deferred ch1 word (stereo).
  assign last_write = (word_cnt == LAST_BASE) && ((CHANNELS == 1) ? wr0 : wr1);
  assign rd_idx     = bus.addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  assign bus.dout     = dout;
  assign bus.word_cnt = word_cnt;

  always_ff @(posedge AHBclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (cmd_start)      state_next = CAPTURE;
        else if (cmd_clear) state_next = IDLE;
      end
      CAPTURE: begin
        if (cmd_abort)       state_next = IDLE;
        else if (last_write) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.bsy  = (state == CAPTURE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge AHBclk) begin
    if (!rst) begin
      sync     <= '0;
      cnt      <= '0;
      pdm_clk  <= 1'b0;
      sr0      <= '0;
      sr1      <= '0;
      bc0      <= '0;
      pend     <= 1'b0;
      word_cnt <= '0;
      dout     <= '0;
    end else begin
      sync <= {sync[0], pdm_in};
      // Words at or beyond word_cnt were not written by the current capture and read as zero.
      dout <= (ready && ({1'b0, rd_idx} < word_cnt)) ? mem[rd_idx] : 32'd0;
      if (cmd_start) begin
        cnt      <= '0;
        pdm_clk  <= 1'b0;
        sr0      <= '0;
        sr1      <= '0;
        bc0      <= '0;
        pend     <= 1'b0;
        word_cnt <= '0;
      end else if (cmd_clear) begin
        word_cnt <= '0;
      end else if (cmd_abort) begin
        cnt     <= '0;
        pdm_clk <= 1'b0;
        pend    <= 1'b0;
      end else if (capturing) begin
        cnt <= tick ? 8'd0 : cnt + 8'd1;
        if (tick) pdm_clk <= ~pdm_clk;
        if (tick && pdm_clk) begin
          sr0 <= {sr0[30:0], sample};
          bc0 <= bc0 + 5'd1;
        end
        if (tick && !pdm_clk && (CHANNELS == 2)) sr1 <= {sr1[30:0], sample};
        // ch1 shares ch0's word slot pair, so its word is committed one cycle after ch0's.
        if (wr0) begin
          if (CHANNELS == 1) word_cnt <= word_cnt + (ADDR_W + 1)'(1);
          else               pend     <= 1'b1;
        end
        if (wr1) begin
          pend     <= 1'b0;
          word_cnt <= word_cnt + (ADDR_W + 1)'(2);
        end
      end
    end
  end

  always_ff @(posedge AHBclk) begin
    if (rst && wr0)      mem[word_cnt[ADDR_W-1:0]] <= {sr0[30:0], sample};
    else if (rst && wr1) mem[word_cnt[ADDR_W-1:0] + ADDR_W'(1)] <= sr1;
  end
endmodule
